// File: rtl/board_scan_ctrl_if.sv
// Register-file access bus between the board scanner and the
// 61-entry board register file: two combinational reads, one write.
interface board_scan_ctrl_if;
    logic [5:0]  src0;
    logic [5:0]  src1;
    logic [5:0]  dst;
    logic        we;
    logic [17:0] data;
    logic [17:0] outa;
    logic [17:0] outb;

    modport master (
        output src0, src1, dst, we, data,
        input  outa, outb
    );

    modport slave (
        input  src0, src1, dst, we, data,
        output outa, outb
    );
endinterface

// File: rtl/board_scan_ctrl.sv
// Board scanner: scores boards two per cycle against a question word.
// Optional BOARD_SCAN_VALIDATE_EN: skip malformed boards, flag via bad.
module board_scan_ctrl #(
    parameter int FIRST    = 0,
    parameter int LAST     = 59,
    parameter int Q_ADDR   = 60,
    parameter int RES_ADDR = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              bad,
    board_scan_ctrl_if.master rf
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOADQ, S_SCAN, S_WRITE, S_DONE
    } state_t;

    localparam logic [2:0] TERM  = 3'b101;
    localparam logic [5:0] FST6  = 6'(FIRST);
    localparam logic [5:0] Q6    = 6'(Q_ADDR);
    localparam logic [5:0] RES6  = 6'(RES_ADDR);
    localparam logic [6:0] LAST7 = 7'(LAST);

    function automatic logic [2:0] f_score(
        input logic [17:0] b,
        input logic [14:0] q
    );
        logic [2:0] s;
        s = '0;
        for (int i = 0; i < 5; i++)
            if (b[3 + i*3 +: 3] == q[i*3 +: 3]) s = s + 3'd1;
        return s;
    endfunction

    state_t      r_state, w_state_nx;
    logic [14:0] r_q, w_q_nx;
    logic [5:0]  r_idx, w_idx_nx;
    logic [2:0]  r_best, w_best_nx;
    logic [5:0]  r_exact, w_exact_nx;
    logic [5:0]  r_ptr, w_ptr_nx;

    logic [2:0]  w_sc_a, w_sc_b;
    logic        w_ok_a, w_ok_b;
    logic        w_in_b, w_last;
    logic        w_use_a, w_use_b;
    logic        w_ex_a, w_ex_b;

`ifdef BOARD_SCAN_VALIDATE_EN
    function automatic logic f_ok(input logic [17:0] b);
        logic ok;
        ok = (b[2:0] == TERM);
        for (int i = 1; i < 6; i++) begin
            if (b[i*3 +: 3] > 3'd4) ok = 1'b0;
            for (int j = i + 1; j < 6; j++)
                if (b[i*3 +: 3] == b[j*3 +: 3]) ok = 1'b0;
        end
        return ok;
    endfunction

    logic r_bad, w_bad_nx;

    assign w_ok_a = f_ok(rf.outa);
    assign w_ok_b = f_ok(rf.outb);
    assign bad    = r_bad;
`else
    logic w_unused;

    assign w_unused = ^{rf.outa[2:0], rf.outb[2:0]};
    assign w_ok_a   = 1'b1;
    assign w_ok_b   = 1'b1;
    assign bad      = 1'b0;
`endif

    assign w_sc_a  = f_score(rf.outa, r_q);
    assign w_sc_b  = f_score(rf.outb, r_q);
    assign w_in_b  = ({1'b0, r_ptr} + 7'd1) <= LAST7;
    assign w_last  = ({1'b0, r_ptr} + 7'd2) > LAST7;
    assign w_use_a = w_ok_a;
    assign w_use_b = w_in_b & w_ok_b;
    assign w_ex_a  = w_use_a & (w_sc_a == 3'd5);
    assign w_ex_b  = w_use_b & (w_sc_b == 3'd5);

    assign rf.src0 = (r_state == S_SCAN) ? r_ptr : Q6;
    assign rf.src1 = (r_state == S_SCAN) ? 6'(r_ptr + 6'd1) : Q6;

    // Next state, scan bookkeeping and write-port outputs.
    always_comb begin
        w_state_nx = r_state;
        w_q_nx     = r_q;
        w_idx_nx   = r_idx;
        w_best_nx  = r_best;
        w_exact_nx = r_exact;
        w_ptr_nx   = r_ptr;
`ifdef BOARD_SCAN_VALIDATE_EN
        w_bad_nx   = r_bad;
`endif
        busy       = 1'b0;
        done       = 1'b0;
        rf.we      = 1'b0;
        rf.dst     = '0;
        rf.data    = '0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_nx = S_LOADQ;
            end
            S_LOADQ: begin
                busy       = 1'b1;
                w_q_nx     = rf.outa[17:3];
                w_idx_nx   = FST6;
                w_best_nx  = '0;
                w_exact_nx = '0;
                w_ptr_nx   = FST6;
`ifdef BOARD_SCAN_VALIDATE_EN
                w_bad_nx   = 1'b0;
`endif
                w_state_nx = S_SCAN;
            end
            S_SCAN: begin
                busy = 1'b1;
                // A first so that equal scores keep the lower index.
                if (w_use_a && (w_sc_a > w_best_nx)) begin
                    w_best_nx = w_sc_a;
                    w_idx_nx  = r_ptr;
                end
                if (w_use_b && (w_sc_b > w_best_nx)) begin
                    w_best_nx = w_sc_b;
                    w_idx_nx  = 6'(r_ptr + 6'd1);
                end
                w_exact_nx = r_exact + {5'd0, w_ex_a} + {5'd0, w_ex_b};
`ifdef BOARD_SCAN_VALIDATE_EN
                w_bad_nx   = r_bad | ~w_ok_a | (w_in_b & ~w_ok_b);
`endif
                w_ptr_nx   = 6'(r_ptr + 6'd2);
                if (w_last) w_state_nx = S_WRITE;
            end
            S_WRITE: begin
                busy       = 1'b1;
                rf.we      = 1'b1;
                rf.dst     = RES6;
                rf.data    = {r_idx, r_best, r_exact, TERM};
                w_state_nx = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register; reset abandons any scan in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    // Question latch, running best and scan pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_idx   <= '0;
            r_best  <= '0;
            r_exact <= '0;
            r_ptr   <= '0;
`ifdef BOARD_SCAN_VALIDATE_EN
            r_bad   <= 1'b0;
`endif
        end else begin
            r_q     <= w_q_nx;
            r_idx   <= w_idx_nx;
            r_best  <= w_best_nx;
            r_exact <= w_exact_nx;
            r_ptr   <= w_ptr_nx;
`ifdef BOARD_SCAN_VALIDATE_EN
            r_bad   <= w_bad_nx;
`endif
        end
    end
endmodule

// File: tb/tb_board_scan_ctrl.sv
// Bench for board_scan_ctrl: vector table, corner sequences and
// randomized images checked against a behavioural scoring model.
module tb_board_scan_ctrl;
    localparam logic [17:0] QDEF = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'b101};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start7 = 1'b0;
    logic busy, done, bad, busy7, done7, bad7;
    logic ld_all = 1'b0;
    logic [17:0] img   [0:60];
    logic [17:0] regs  [0:60];
    logic [17:0] regs7 [0:60];
    int n_chk = 0;
    int n_err = 0;
    bit sel7 = 1'b0;

    board_scan_ctrl_if rf ();
    board_scan_ctrl_if rf7 ();

    always #5 clk = ~clk;

    board_scan_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .bad(bad), .rf(rf)
    );

    board_scan_ctrl #(.FIRST(7), .LAST(7)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .start(start7),
        .busy(busy7), .done(done7), .bad(bad7), .rf(rf7)
    );

    assign rf.outa  = (rf.src0  <= 6'd60) ? regs[rf.src0]   : '0;
    assign rf.outb  = (rf.src1  <= 6'd60) ? regs[rf.src1]   : '0;
    assign rf7.outa = (rf7.src0 <= 6'd60) ? regs7[rf7.src0] : '0;
    assign rf7.outb = (rf7.src1 <= 6'd60) ? regs7[rf7.src1] : '0;

    always @(posedge clk) begin
        if (ld_all) begin
            for (int i = 0; i < 61; i++) begin
                regs[i]  <= img[i];
                regs7[i] <= img[i];
            end
        end else begin
            if (rf.we && rf.dst <= 6'd60)   regs[rf.dst]   <= rf.data;
            if (rf7.we && rf7.dst <= 6'd60) regs7[rf7.dst] <= rf7.data;
        end
    end

    logic        o_busy, o_done, o_bad, o_we;
    logic [5:0]  o_dst;
    logic [17:0] o_data;
    assign o_busy = sel7 ? busy7    : busy;
    assign o_done = sel7 ? done7    : done;
    assign o_bad  = sel7 ? bad7     : bad;
    assign o_we   = sel7 ? rf7.we   : rf.we;
    assign o_dst  = sel7 ? rf7.dst  : rf.dst;
    assign o_data = sel7 ? rf7.data : rf.data;

    typedef struct {
        logic [17:0] q;
        bit          d7;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [17:0] perm(int a, int b, int c, int d, int e);
        return {3'(a), 3'(b), 3'(c), 3'(d), 3'(e), 3'b101};
    endfunction

    function automatic void build_img();
        logic [17:0] w;
        int n;
        img[0]  = perm(0, 1, 2, 3, 4);
        img[1]  = perm(0, 1, 3, 4, 2);
        img[2]  = perm(1, 2, 0, 3, 4);
        img[59] = perm(4, 3, 2, 1, 0);
        img[60] = QDEF;
        n = 3;
        for (int k = 0; k < 3125; k++) begin
            int a, b, c, d, e;
            a = k % 5; b = (k / 5) % 5; c = (k / 25) % 5;
            d = (k / 125) % 5; e = k / 625;
            if (((1 << a) | (1 << b) | (1 << c) | (1 << d) | (1 << e)) == 31) begin
                w = perm(a, b, c, d, e);
                if (n < 59 && w != img[0] && w != img[1] &&
                    w != img[2] && w != img[59]) begin
                    img[n] = w;
                    n++;
                end
            end
        end
    endfunction

    function automatic bit well_formed(input logic [17:0] w);
        bit seen [8];
        int dg;
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
        if (w[2:0] != 3'b101) return 1'b0;
        for (int f = 1; f < 6; f++) begin
            dg = int'(w[f*3 +: 3]);
            if (dg > 4 || seen[dg]) return 1'b0;
            seen[dg] = 1'b1;
        end
        return 1'b1;
    endfunction

    function automatic void model(input logic [17:0] q, input int first,
                                  input int last, output logic [17:0] res,
                                  output bit b);
        int best, bidx, ex, s;
        best = 0; bidx = first; ex = 0; b = 1'b0;
        for (int i = first; i <= last; i++) begin
            s = 0;
            for (int f = 1; f < 6; f++)
                if (img[i][f*3 +: 3] == q[f*3 +: 3]) s++;
`ifdef BOARD_SCAN_VALIDATE_EN
            if (!well_formed(img[i])) begin
                b = 1'b1;
                continue;
            end
`endif
            if (s > best) begin
                best = s;
                bidx = i;
            end
            if (s == 5) ex++;
        end
        res = {6'(bidx), 3'(best), 6'(ex), 3'b101};
    endfunction

    task automatic chk(input string nm, input string tag,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h want %0h", nm, tag, act, exp);
        end
    endtask

    task automatic load(input logic [17:0] q);
        img[60] = q;
        ld_all = 1'b1;
        @(posedge clk); #1;
        ld_all = 1'b0;
    endtask

    task automatic run_scan(input bit d7, input logic [17:0] exp,
                            input bit exp_bad, input int restart,
                            input string nm);
        int wcyc, nwe, wat, dat, ndone, busy_bad;
        logic [17:0] wdata, rfv;
        logic [5:0] wdst;
        logic badv;
        sel7 = d7;
        wcyc = d7 ? 3 : 32;
        nwe = 0; ndone = 0; wat = -1; dat = -1; busy_bad = 0;
        wdata = '0; wdst = '0; rfv = '0; badv = 1'b0;
        if (d7) start7 = 1'b1;
        else    start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start7 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (o_we) begin
                nwe++; wat = k; wdata = o_data; wdst = o_dst;
            end
            if (o_done) begin
                ndone++; dat = k;
            end
            if (o_busy !== (k <= wcyc)) busy_bad++;
            if (k == wcyc + 1) begin
                rfv  = d7 ? regs7[2] : regs[2];
                badv = o_bad;
            end
            if (d7) start7 = (k == restart);
            else    start  = (k == restart);
            @(posedge clk); #1;
        end
        start = 1'b0; start7 = 1'b0;
        chk(nm, "we_count", nwe, 1);
        chk(nm, "we_cycle", wat, wcyc);
        chk(nm, "dst", 32'(wdst), 2);
        chk(nm, "data", 32'(wdata), 32'(exp));
        chk(nm, "done_count", ndone, 1);
        chk(nm, "done_cycle", dat, wcyc + 1);
        chk(nm, "busy_shape", busy_bad, 0);
        chk(nm, "rf_result", 32'(rfv), 32'(exp));
        chk(nm, "bad", 32'(badv), 32'(exp_bad));
    endtask

    initial begin
        logic [17:0] e;
        bit eb;
        int nwe;
        build_img();
        repeat (3) @(posedge clk);
        #1;
        chk("reset", "busy", 32'(busy), 0);
        chk("reset", "done", 32'(done), 0);
        chk("reset", "we", 32'(rf.we), 0);
        chk("reset", "dst", 32'(rf.dst), 0);
        chk("reset", "data", 32'(rf.data), 0);
        chk("reset", "bad", 32'(bad), 0);
        chk("reset", "src0", 32'(rf.src0), 60);
        chk("reset", "src1", 32'(rf.src1), 60);
        chk("reset", "src0_7", 32'(rf7.src0), 60);
        rst_n = 1'b1;

        tbl[0] = '{QDEF, 1'b0, {6'd59, 3'd5, 6'd1, 3'b101}};
        tbl[1] = '{perm(0, 1, 2, 3, 4), 1'b0, {6'd0, 3'd5, 6'd1, 3'b101}};
        tbl[2] = '{perm(0, 1, 3, 4, 2), 1'b0, {6'd1, 3'd5, 6'd1, 3'b101}};
        tbl[3] = '{perm(1, 2, 0, 3, 4), 1'b0, {6'd2, 3'd5, 6'd1, 3'b101}};
        tbl[4] = '{perm(7, 7, 7, 7, 7), 1'b0, {6'd0, 3'd0, 6'd0, 3'b101}};
        tbl[5] = '{img[7], 1'b1, {6'd7, 3'd5, 6'd1, 3'b101}};
        for (int t = 0; t < 6; t++) begin
            build_img();
            load(tbl[t].q);
            run_scan(tbl[t].d7, tbl[t].exp, 1'b0, 0, $sformatf("vec%0d", t));
        end

        build_img();
        load(QDEF);
        run_scan(1'b0, {6'd59, 3'd5, 6'd1, 3'b101}, 1'b0, 10, "restart10");

        build_img();
        load(QDEF);
        sel7 = 1'b0;
        nwe = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (rf.we) nwe++;
            if (k == 15) rst_n = 1'b0;
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        chk("midreset", "busy", 32'(busy), 0);
        chk("midreset", "src0", 32'(rf.src0), 60);
        chk("midreset", "done", 32'(done), 0);
        for (int k = 0; k < 40; k++) begin
            if (rf.we) nwe++;
            @(posedge clk); #1;
        end
        chk("midreset", "we_seen", nwe, 0);
        chk("midreset", "rf2", 32'(regs[2]), 32'(img[2]));
        run_scan(1'b0, {6'd59, 3'd5, 6'd1, 3'b101}, 1'b0, 0, "after_reset");

        build_img();
        model(img[8], 7, 7, e, eb);
        load(img[8]);
        run_scan(1'b1, e, eb, 0, "b_ignored");

        build_img();
        img[5] = {3'd0, 3'd0, 3'd2, 3'd3, 3'd4, 3'b101};
        load(img[5]);
`ifdef BOARD_SCAN_VALIDATE_EN
        run_scan(1'b0, {6'd0, 3'd4, 6'd0, 3'b101}, 1'b1, 0, "malformed");
`else
        run_scan(1'b0, {6'd5, 3'd5, 6'd1, 3'b101}, 1'b0, 0, "malformed");
`endif

        for (int r = 0; r < 8; r++) begin
            logic [17:0] q;
            build_img();
            for (int i = 0; i < 60; i++) begin
                int c;
                c = $urandom_range(0, 3);
                if (c == 1) img[i] = {15'($urandom), 3'b101};
                else if (c == 2) img[i] = 18'($urandom);
                else if (c == 3) img[i] = img[$urandom_range(0, 59)];
            end
            if ($urandom_range(0, 1) == 1) q = img[$urandom_range(0, 59)];
            else q = 18'($urandom);
            model(q, 0, 59, e, eb);
            load(q);
            run_scan(1'b0, e, eb,
                     (r % 2 == 1) ? int'($urandom_range(2, 33)) : 0,
                     $sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/board_scan_ctrl.md
# board_scan_ctrl

Sequencing master on the read/write side of the 61-entry, 18-bit board register file. On a start pulse it latches the question word, reads every candidate board through both read ports (two boards per cycle), scores each board by exact-position digit matches, and writes one packed result word back into the register file through its write port. It is the consumer and initiator that drives `src0`/`src1`/`dst`/`we`/`data` into the register file.

## Interface
- `FIRST`, 0, index of first candidate board
- `LAST`, 59, index of last candidate board (inclusive, `LAST >= FIRST`)
- `Q_ADDR`, 60, register holding the question word
- `RES_ADDR`, 2, register receiving the result word

- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle request to begin a scan
- `outa`  in  18  register-file read data for `src0` (combinational, same cycle)
- `outb`  in  18  register-file read data for `src1` (combinational, same cycle)
- `src0`  out  6  read address A
- `src1`  out  6  read address B
- `dst`  out  6  write address
- `we`  out  1  write enable
- `data`  out  18  write data
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle completion pulse
- `bad`  out  1  at least one malformed board seen in last scan (validation build only)

## Operation
- Board word: six 3-bit fields, [17:15]..[5:3] are digits, [2:0] is terminator `3'b101`.
- Score = number of digit fields i in 0..4 where board field i equals question field i; range 0..5, 3 bits.
- States: IDLE, LOADQ, SCAN, WRITE, DONE.
- IDLE: `src0=Q_ADDR`, `src1=Q_ADDR`, `we=0`. `start=1` -> LOADQ.
- LOADQ: latch `outa` as question; clear best_idx=FIRST, best_score=0, exact_cnt=0, bad=0; ptr=FIRST -> SCAN.
- SCAN: `src0=ptr`, `src1=ptr+1`. Score both. Board B ignored when `ptr+1 > LAST`. Update best only on strictly greater score; A evaluated before B, so ties keep the lower index. exact_cnt increments per board scoring 5 (0, 1 or 2 per cycle). ptr += 2; when `ptr+2 > LAST` -> WRITE.
- WRITE: `we=1`, `dst=RES_ADDR`, `data={best_idx[5:0], best_score[2:0], exact_cnt[5:0], 3'b101}` -> DONE.
- DONE: `done=1`, `busy=0` -> IDLE.
- `start` outside IDLE is ignored; not queued.
- `we` is asserted only in WRITE; `dst`/`data` are 0 in all other states.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `we=0`, `dst=0`, `data=0`, `bad=0`, `src0=src1=Q_ADDR`.
- Start sampled in cycle 0; LOADQ cycle 1; SCAN cycles 2..(1+S) with S = ceil((LAST-FIRST+1)/2); WRITE cycle 2+S; DONE cycle 3+S.
- Defaults: S=30, write in cycle 32, `done` high in cycle 33, next `start` accepted from cycle 34.
- `busy` high from cycle 1 through the WRITE cycle inclusive.
- Result word visible in the register file from cycle after WRITE (register-file write is clocked).
- Single-board range (FIRST=LAST): S=1, B ignored.
- `rst_n=0` in any state: next edge returns to IDLE with reset values; no WRITE occurs, partial results discarded.

## Configuration
- `BOARD_SCAN_VALIDATE_EN` defined: a board is malformed if terminator != `3'b101`, any digit > 4, or any two digits equal. Malformed boards are never scored, never become best, never count toward exact_cnt, and set `bad` (held until next LOADQ).
- Not defined: no validation logic; every board scored as-is; `bad` tied to 0.

## Test plan
- Register file at reset values (question `100_011_010_001_000_101`), start -> WRITE in cycle 32 with `dst=2`, `data={6'd59,3'd5,6'd1,3'b101}`, `done` in cycle 33.
- Question replaced with `000_001_010_011_100_101` (board 0 pattern), start -> `data={6'd0,3'd5,6'd1,3'b101}`; tie handling verified with boards 1 and 2 both scoring 2, index 0 wins regardless.
- FIRST=LAST=7, question = board 7 pattern -> S=1, write in cycle 3, `data={6'd7,3'd5,6'd1,3'b101}`, `src1` read ignored.
- `start` pulsed again in cycle 10 of a scan -> ignored; exactly one write, `done` in cycle 33 only.
- `rst_n` low in cycle 15 -> `we` never asserts, `busy=0` next cycle; fresh start then completes normally with 34-cycle schedule.
- Validation build: board 5 overwritten with `000_000_010_011_100_101` and question equal to it -> board 5 skipped, `bad=1`, result index != 5; non-validation build scores it 5 and reports index 5, `bad=0`.
